regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 11 +
 rtl/regfile_sb_scoreboard.sv | 37 +++
 rtl/regfile_sb.sv | 103 ++++++++++
 tb/tb_regfile_sb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefNumRegs = 32;

    function automatic int unsigned addr_width(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending bits: issue sets, committed write clears, set beats clear.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned NUM_REGS = DefNumRegs,
    localparam int unsigned AW = addr_width(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic [NUM_REGS-1:0] clr_vec_i,
    output logic [NUM_REGS-1:0] busy_vec_o
);

    logic [NUM_REGS-1:0] busy_d, busy_q;

    always_comb begin
        busy_d = busy_q & ~clr_vec_i;
        // Applied after the clear so a new producer supersedes the retiring one.
        if (iss_en_i && (iss_addr_i != '0)) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write bypass and an issue scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    localparam int unsigned AW = addr_width(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    output logic [NUM_REGS-1:0]   busy_vec,
    input  logic [AW-1:0]         dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    logic [AW-1:0]       wr_addr_a [NWR];
    logic [DATA_W-1:0]   wr_data_a [NWR];
    logic [NWR-1:0]      wr_commit;
    logic [NUM_REGS-1:0] clr_vec;

    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic [DATA_W-1:0] mem_q [NUM_REGS];

    for (genvar j = 0; j < NWR; j++) begin : g_wr
        assign wr_addr_a[j] = wr_addr[j*AW +: AW];
        assign wr_data_a[j] = wr_data[j*DATA_W +: DATA_W];
        assign wr_commit[j] = wr_en[j] && (wr_addr_a[j] != '0);
    end

    // Ascending port order lets the higher port win an address collision.
    always_comb begin
        mem_d   = mem_q;
        clr_vec = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_commit[j]) begin
                mem_d[wr_addr_a[j]]   = wr_data_a[j];
                clr_vec[wr_addr_a[j]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    regfile_sb_scoreboard #(
        .NUM_REGS(NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_en_i  (iss_en),
        .iss_addr_i(iss_addr),
        .clr_vec_i (clr_vec),
        .busy_vec_o(busy_vec)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic              active;
        logic              hit;
        logic [DATA_W-1:0] byp;

        assign addr   = rd_addr[k*AW +: AW];
        assign active = rd_en[k] && (addr != '0);

        // Bypass is suppressed during reset so outputs read 0 regardless of writes.
        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int j = 0; j < NWR; j++) begin
                if (rst_n && wr_commit[j] && (wr_addr_a[j] == addr)) begin
                    hit = 1'b1;
                    byp = wr_data_a[j];
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = !active ? '0 : (hit ? byp : mem_q[addr]);
        assign rd_busy[k] = active && busy_vec[addr] && !hit;
    end

    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb against an array-based reference model.
module tb_regfile_sb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    rd_en = '0;
    logic [9:0]    rd_addr = '0;
    logic [63:0]   rd_data;
    logic [1:0]    rd_busy;
    logic [1:0]    wr_en = '0;
    logic [9:0]    wr_addr = '0;
    logic [63:0]   wr_data = '0;
    logic          iss_en = 1'b0;
    logic [4:0]    iss_addr = '0;
    logic [31:0]   busy_vec;
    logic [4:0]    dbg_addr = '0;
    logic [31:0]   dbg_data;

    int total = 0;
    int bad = 0;

    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    regfile_sb dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .busy_vec(busy_vec),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = '0;
    endfunction

    // Value a read port should show right now, from the architectural rules.
    function automatic logic [31:0] model_rd(input int k);
        logic [4:0] a;
        logic [31:0] v;
        a = rd_addr[k*AW +: AW];
        if (!rst_n || !rd_en[k] || a == 0) return '0;
        v = m_mem[a];
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*DW +: DW];
        return v;
    endfunction

    function automatic logic model_busy(input int k);
        logic [4:0] a;
        a = rd_addr[k*AW +: AW];
        if (!rd_en[k] || a == 0 || !m_busy[a]) return 1'b0;
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cycle();
        logic [4:0] a;
        @(posedge clk);
        if (rst_n) begin
            for (int j = 0; j < 2; j++) begin
                a = wr_addr[j*AW +: AW];
                if (wr_en[j] && a != 0) begin
                    m_mem[a] = wr_data[j*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = '0;
        wr_en = '0;
        iss_en = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        rst_n = 1'b0;
        wr_en = 2'b11;
        wr_addr = {5'd6, 5'd5};
        wr_data = {32'h1111_2222, 32'h3333_4444};
        iss_en = 1'b1;
        iss_addr = 5'd7;
        rd_en = 2'b11;
        rd_addr = {5'd6, 5'd5};
        cycle();
        cycle();
        total++;
        if (busy_vec !== 32'h0) begin
            bad++;
            $display("FAIL reset_busy_vec got=%h exp=0", busy_vec);
        end
        total++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            bad++;
            $display("FAIL reset_rd got=%h busy=%b exp=0", rd_data, rd_busy);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #0.1;
            total++;
            if (dbg_data !== 32'h0) begin
                bad++;
                $display("FAIL reset_dbg addr=%0d got=%h exp=0", i, dbg_data);
            end
        end
        idle_inputs();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_bypass_priority();
        wr_en = 2'b11;
        wr_addr = {5'd5, 5'd5};
        wr_data = {32'h5555_FFFF, 32'hAAAA_0000};
        rd_en = 2'b01;
        rd_addr = {5'd0, 5'd5};
        #2;
        total++;
        if (rd_data[31:0] !== 32'h5555_FFFF) begin
            bad++;
            $display("FAIL bypass_prio got=%h exp=5555ffff", rd_data[31:0]);
        end
        cycle();
        idle_inputs();
        dbg_addr = 5'd5;
        #1;
        total++;
        if (dbg_data !== 32'h5555_FFFF) begin
            bad++;
            $display("FAIL write_prio_storage got=%h exp=5555ffff", dbg_data);
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'h0, 32'hDEAD_BEEF};
        iss_en = 1'b1;
        iss_addr = 5'd0;
        rd_en = 2'b01;
        rd_addr = {5'd0, 5'd0};
        #2;
        total++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL zero_bypass got=%h busy=%b exp=0", rd_data[31:0], rd_busy[0]);
        end
        cycle();
        iss_en = 1'b0;
        wr_en = '0;
        dbg_addr = 5'd0;
        #1;
        total++;
        if (busy_vec[0] !== 1'b0 || rd_data[31:0] !== 32'h0 || dbg_data !== 32'h0) begin
            bad++;
            $display("FAIL zero_reg busy=%b rd=%h dbg=%h exp=0", busy_vec[0], rd_data[31:0],
                     dbg_data);
        end
        idle_inputs();
    endtask

    task automatic test_hazard();
        iss_en = 1'b1;
        iss_addr = 5'd17;
        cycle();
        iss_en = 1'b0;
        rd_en = 2'b01;
        rd_addr = {5'd0, 5'd17};
        #1;
        total++;
        if (rd_busy[0] !== 1'b1 || busy_vec[17] !== 1'b1) begin
            bad++;
            $display("FAIL hazard_set rd_busy=%b busy17=%b exp=1", rd_busy[0], busy_vec[17]);
        end
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd17};
        wr_data = {32'h0, 32'h12};
        #1;
        total++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h12) begin
            bad++;
            $display("FAIL hazard_bypass rd_busy=%b data=%h exp=0/12", rd_busy[0], rd_data[31:0]);
        end
        cycle();
        wr_en = '0;
        #1;
        total++;
        if (busy_vec[17] !== 1'b0 || rd_data[31:0] !== 32'h12 || rd_busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL hazard_clear busy17=%b data=%h rd_busy=%b exp=0/12/0", busy_vec[17],
                     rd_data[31:0], rd_busy[0]);
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        iss_en = 1'b1;
        iss_addr = 5'd9;
        cycle();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'hCAFE_0009};
        cycle();
        idle_inputs();
        dbg_addr = 5'd9;
        #1;
        total++;
        if (busy_vec[9] !== 1'b1 || dbg_data !== 32'hCAFE_0009) begin
            bad++;
            $display("FAIL set_beats_clear busy9=%b data=%h exp=1/cafe0009", busy_vec[9],
                     dbg_data);
        end
    endtask

    task automatic test_async_reset();
        iss_en = 1'b1;
        iss_addr = 5'd3;
        wr_en = 2'b10;
        wr_addr = {5'd4, 5'd0};
        wr_data = {32'h77, 32'h0};
        cycle();
        idle_inputs();
        dbg_addr = 5'd4;
        #1;
        total++;
        if (busy_vec[3] !== 1'b1 || dbg_data !== 32'h77) begin
            bad++;
            $display("FAIL pre_reset busy3=%b dbg=%h exp=1/77", busy_vec[3], dbg_data);
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        total++;
        if (busy_vec !== 32'h0 || dbg_data !== 32'h0) begin
            bad++;
            $display("FAIL async_reset busy=%h dbg=%h exp=0/0", busy_vec, dbg_data);
        end
        rst_n = 1'b1;
        iss_en = 1'b1;
        iss_addr = 5'd3;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd4};
        wr_data = {32'h0, 32'h88};
        cycle();
        idle_inputs();
        #1;
        total++;
        if (busy_vec !== 32'h8 || dbg_data !== 32'h88) begin
            bad++;
            $display("FAIL post_release busy=%h dbg=%h exp=8/88", busy_vec, dbg_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] mask;
        for (int n = 0; n < 400; n++) begin
            mask = ($urandom_range(0, 3) == 0) ? 32'd31 : 32'd7;
            rd_en = 2'($urandom);
            rd_addr = {5'($urandom & mask), 5'($urandom & mask)};
            wr_en = 2'($urandom);
            wr_addr = {5'($urandom & mask), 5'($urandom & mask)};
            wr_data = {$urandom, $urandom};
            iss_en = 1'($urandom);
            iss_addr = 5'($urandom & mask);
            dbg_addr = 5'($urandom & mask);
            #2;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd_data[k*DW +: DW] !== model_rd(k) || rd_busy[k] !== model_busy(k)) begin
                    bad++;
                    $display("FAIL rand_rd%0d it=%0d got=%h/%b exp=%h/%b", k, n,
                             rd_data[k*DW +: DW], rd_busy[k], model_rd(k), model_busy(k));
                end
            end
            total++;
            if (busy_vec !== m_busy || dbg_data !== m_mem[dbg_addr]) begin
                bad++;
                $display("FAIL rand_state it=%0d busy=%h exp=%h dbg=%h exp=%h", n, busy_vec,
                         m_busy, dbg_data, m_mem[dbg_addr]);
            end
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_bypass_priority();
        test_zero_reg();
        test_hazard();
        test_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
